// File: rtl/dual_sram_lane.sv
`default_nettype none
// ============================================================================
// Module   : dual_sram_lane
// Purpose  : Simple dual-port SRAM with one write port and one read port on a
//            single clock. It stores operand vectors for the dot-product
//            datapath. The loader writes through the write port and the
//            compute engine reads through the read port.
//            Features:
//              - per-lane write masking
//              - registered read data with a one-cycle valid flag
//              - write-first forwarding when both ports hit the same address
//              - multi-cycle clear sweep, flagged by Busy
// Macro    : DUAL_SRAM_OUT_REG_EN adds a second output register stage, which
//            makes the read latency 2. It is disabled by default (latency 1).
// Ports    : clk          - clock; all state changes on the rising edge
//            Rst_n        - synchronous active-low reset
//            Mem_Clear    - one-cycle pulse that starts the clear sweep
//            Chip_Select  - gates both ports (does not gate the clear sweep)
//            En_Write     - write request
//            Write_Addr   - write address
//            Write_Data   - write data
//            Write_Mask   - per-lane write enable
//            En_Read      - read request
//            Read_Addr    - read address
//            Read_Data    - registered read data
//            Read_Valid   - one-cycle strobe that marks new Read_Data
//            Busy         - high while the clear sweep runs
// Revision : 1.0 - initial release
// ============================================================================
module dual_sram_lane #(
  parameter int DATA_WIDTH  = 8,
  parameter int LANE_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int RAM_DEPTH   = 1 << ADDR_WIDTH,
  localparam int NUM_LANES  = DATA_WIDTH / LANE_WIDTH
) (
  input  logic                  clk,
  input  logic                  Rst_n,
  input  logic                  Mem_Clear,
  input  logic                  Chip_Select,
  input  logic                  En_Write,
  input  logic [ADDR_WIDTH-1:0] Write_Addr,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  input  logic [NUM_LANES-1:0]  Write_Mask,
  input  logic                  En_Read,
  input  logic [ADDR_WIDTH-1:0] Read_Addr,
  output logic [DATA_WIDTH-1:0] Read_Data,
  output logic                  Read_Valid,
  output logic                  Busy
);

  // The array may be shallower than the address space. Indices are therefore
  // only as wide as the implemented depth needs. Out-of-range addresses are
  // screened before the index is used, so truncation never aliases.
  localparam int IDX_WIDTH = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [IDX_WIDTH-1:0] c_last_idx = IDX_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

  state_t                r_state;
  logic [IDX_WIDTH-1:0]  r_clr_ptr;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic                  w_clr_fire;
  logic                  w_collide;
  logic [IDX_WIDTH-1:0]  w_wr_idx;
  logic [IDX_WIDTH-1:0]  w_rd_idx;
  logic [DATA_WIDTH-1:0] w_rd_mem;
  logic [DATA_WIDTH-1:0] w_rd_fwd;
  logic [DATA_WIDTH-1:0] w_rd_word;

  assign w_wr_in_range = (32'(Write_Addr) < RAM_DEPTH);
  assign w_rd_in_range = (32'(Read_Addr)  < RAM_DEPTH);
  assign w_wr_idx      = Write_Addr[IDX_WIDTH-1:0];
  assign w_rd_idx      = Read_Addr[IDX_WIDTH-1:0];

  // Reset has priority over every other input. Array updates are therefore
  // gated with Rst_n even though the array itself is never reset.
  assign w_wr_fire  = Rst_n & Chip_Select & En_Write & ~r_busy & w_wr_in_range;
  assign w_rd_fire  = Rst_n & Chip_Select & En_Read  & ~r_busy;
  assign w_clr_fire = Rst_n & (r_state == ST_CLEAR);

  // Write-first forwarding: when both ports hit the same word in the same
  // cycle, masked lanes take the incoming data and the other lanes take the
  // stored data.
  assign w_collide = w_wr_fire & (Write_Addr == Read_Addr);
  assign w_rd_mem  = r_mem[w_rd_idx];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane_fwd
    assign w_rd_fwd[l*LANE_WIDTH +: LANE_WIDTH] =
      (w_collide && Write_Mask[l]) ? Write_Data[l*LANE_WIDTH +: LANE_WIDTH]
                                   : w_rd_mem[l*LANE_WIDTH +: LANE_WIDTH];
  end

  assign w_rd_word = w_rd_in_range ? w_rd_fwd : '0;

  // Storage array. The clear sweep and a port write never fire in the same
  // cycle, because writes are blocked while the sweep runs.
  always_ff @(posedge clk) begin
    if (w_clr_fire) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_wr_fire) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (Write_Mask[l]) begin
          r_mem[w_wr_idx][l*LANE_WIDTH +: LANE_WIDTH] <=
            Write_Data[l*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // Clear-sweep control. Busy is registered alongside the state, so it is
  // high for exactly RAM_DEPTH cycles.
  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      r_state   <= ST_IDLE;
      r_clr_ptr <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Mem_Clear) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (r_clr_ptr == c_last_idx) begin
            r_clr_ptr <= '0;
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
          end else begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_clr_ptr <= '0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // First read stage. Data holds its value between reads.
  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_data <= w_rd_word;
      end
    end
  end

`ifdef DUAL_SRAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;

  // This stage is not gated by Busy. A read accepted just before a clear
  // starts is therefore still delivered.
  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_rd_valid;
      if (r_rd_valid) begin
        r_out_data <= r_rd_data;
      end
    end
  end

  assign Read_Data  = r_out_data;
  assign Read_Valid = r_out_valid;
`else
  assign Read_Data  = r_rd_data;
  assign Read_Valid = r_rd_valid;
`endif

  assign Busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dual_sram_lane.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_sram_lane
// Purpose  : Self-checking bench for dual_sram_lane. The DUT is configured
//            with 16-bit words, 8-bit lanes, 5-bit addresses and 16 words.
//            Read results are queued with their due cycle and compared as
//            they arrive. Honours DUAL_SRAM_OUT_REG_EN (latency 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_sram_lane;

`ifdef DUAL_SRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        Rst_n;
  logic        Mem_Clear;
  logic        Chip_Select;
  logic        En_Write;
  logic [4:0]  Write_Addr;
  logic [15:0] Write_Data;
  logic [1:0]  Write_Mask;
  logic        En_Read;
  logic [4:0]  Read_Addr;
  logic [15:0] Read_Data;
  logic        Read_Valid;
  logic        Busy;

  dual_sram_lane #(
    .DATA_WIDTH(16),
    .LANE_WIDTH(8),
    .ADDR_WIDTH(5),
    .RAM_DEPTH (16)
  ) u_dut (
    .clk        (clk),
    .Rst_n      (Rst_n),
    .Mem_Clear  (Mem_Clear),
    .Chip_Select(Chip_Select),
    .En_Write   (En_Write),
    .Write_Addr (Write_Addr),
    .Write_Data (Write_Data),
    .Write_Mask (Write_Mask),
    .En_Read    (En_Read),
    .Read_Addr  (Read_Addr),
    .Read_Data  (Read_Data),
    .Read_Valid (Read_Valid),
    .Busy       (Busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        mc;
    logic        cs;
    logic        we;
    logic [4:0]  wa;
    logic [15:0] wd;
    logic [1:0]  wm;
    logic        re;
    logic [4:0]  ra;
    logic        fire;
    logic [15:0] ex;
  } vec_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } sb_t;

  sb_t         sb[$];
  vec_t        tbl[$];
  int          cyc   = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] last_data = 16'h0;

  function automatic vec_t mk(input logic mc, input logic cs, input logic we,
                              input logic [4:0] wa, input logic [15:0] wd,
                              input logic [1:0] wm, input logic re,
                              input logic [4:0] ra, input logic fire,
                              input logic [15:0] ex);
    vec_t v;
    v.mc = mc; v.cs = cs; v.we = we; v.wa = wa; v.wd = wd; v.wm = wm;
    v.re = re; v.ra = ra; v.fire = fire; v.ex = ex;
    return v;
  endfunction

  function automatic vec_t v_wr(input logic [4:0] wa, input logic [15:0] wd,
                                input logic [1:0] wm);
    return mk(1'b0, 1'b1, 1'b1, wa, wd, wm, 1'b0, 5'd0, 1'b0, 16'h0);
  endfunction

  function automatic vec_t v_rd(input logic [4:0] ra, input logic [15:0] ex);
    return mk(1'b0, 1'b1, 1'b0, 5'd0, 16'h0, 2'b00, 1'b1, ra, 1'b1, ex);
  endfunction

  function automatic vec_t v_idle();
    return mk(1'b0, 1'b0, 1'b0, 5'd0, 16'h0, 2'b00, 1'b0, 5'd0, 1'b0, 16'h0);
  endfunction

  // Compares the read outputs after every edge. A due scoreboard entry needs
  // a valid strobe with matching data. Otherwise valid must be low and the
  // data must hold its last value.
  task automatic check_out(input string tag);
    sb_t e;
    n_vec++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (Read_Valid !== 1'b1 || Read_Data !== e.data) begin
        n_err++;
        $display("FAIL %s (cycle %0d): Read_Valid=%0b Read_Data=%h, expected valid=1 data=%h",
                 tag, cyc, Read_Valid, Read_Data, e.data);
      end
      last_data = e.data;
    end else begin
      if (Read_Valid !== 1'b0 || Read_Data !== last_data) begin
        n_err++;
        $display("FAIL %s (cycle %0d): Read_Valid=%0b Read_Data=%h, expected valid=0 data=%h",
                 tag, cyc, Read_Valid, Read_Data, last_data);
      end
    end
  endtask

  task automatic chk_busy(input logic e, input string tag);
    n_vec++;
    if (Busy !== e) begin
      n_err++;
      $display("FAIL %s (cycle %0d): Busy=%0b expected %0b", tag, cyc, Busy, e);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    Mem_Clear   = v.mc;
    Chip_Select = v.cs;
    En_Write    = v.we;
    Write_Addr  = v.wa;
    Write_Data  = v.wd;
    Write_Mask  = v.wm;
    En_Read     = v.re;
    Read_Addr   = v.ra;
    if (v.fire) sb.push_back('{due: cyc + LAT, data: v.ex});
    @(posedge clk);
    #1;
    cyc++;
    check_out(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d expected below 1000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    Rst_n = 1'b0;
    Mem_Clear = 1'b0; Chip_Select = 1'b0; En_Write = 1'b0; Write_Addr = '0;
    Write_Data = '0; Write_Mask = '0; En_Read = 1'b0; Read_Addr = '0;

    // Reset for two cycles.
    apply(v_idle(), "reset");
    chk_busy(1'b0, "reset_busy");
    apply(v_idle(), "reset");
    chk_busy(1'b0, "reset_busy");
    Rst_n = 1'b1;

    // Vector table.
    for (int k = 0; k < 16; k++) tbl.push_back(v_wr(5'(k), 16'(k + 3), 2'b11));
    for (int k = 0; k < 16; k++) tbl.push_back(v_rd(5'(k), 16'(k + 3)));
    // Lane mask tests.
    tbl.push_back(v_wr(5'd5, 16'hABCD, 2'b11));
    tbl.push_back(v_wr(5'd5, 16'h1234, 2'b01));
    tbl.push_back(v_rd(5'd5, 16'hAB34));
    // Upper-lane collision: the merged word is forwarded.
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 5'd5, 16'h9900, 2'b10, 1'b1, 5'd5, 1'b1, 16'h9934));
    tbl.push_back(v_rd(5'd5, 16'h9934));
    // Full-mask collision, then mask-0 collision.
    tbl.push_back(v_wr(5'd7, 16'h0055, 2'b11));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 5'd7, 16'h00AA, 2'b11, 1'b1, 5'd7, 1'b1, 16'h00AA));
    tbl.push_back(v_wr(5'd7, 16'h0055, 2'b11));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 5'd7, 16'h00AA, 2'b00, 1'b1, 5'd7, 1'b1, 16'h0055));
    tbl.push_back(v_rd(5'd7, 16'h0055));
    // Simultaneous write and read to different addresses.
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 5'd8, 16'h1111, 2'b11, 1'b1, 5'd9, 1'b1, 16'h000C));
    tbl.push_back(v_rd(5'd8, 16'h1111));
    // Chip_Select low suppresses both ports.
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 5'd3, 16'hDEAD, 2'b11, 1'b1, 5'd3, 1'b0, 16'h0));
    tbl.push_back(v_rd(5'd3, 16'h0006));
    // Out-of-range accesses: the write is dropped and the read returns zero.
    tbl.push_back(v_wr(5'd18, 16'hBEEF, 2'b11));
    tbl.push_back(v_rd(5'd2, 16'h0005));
    tbl.push_back(v_rd(5'd20, 16'h0000));
    tbl.push_back(v_rd(5'd18, 16'h0000));
    // Write with an all-zero mask is a no-op.
    tbl.push_back(v_wr(5'd4, 16'hFFFF, 2'b00));
    tbl.push_back(v_rd(5'd4, 16'h0007));
    tbl.push_back(v_rd(5'd15, 16'h0012));
    tbl.push_back(v_idle());
    tbl.push_back(v_idle());

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Clear sweep.
    for (int k = 0; k < 16; k++) apply(v_wr(5'(k), 16'hFFFF, 2'b11), "fill_ff");
    // A read issued together with Mem_Clear is still delivered.
    apply(mk(1'b1, 1'b1, 1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd1, 1'b1, 16'hFFFF), "clr_start");
    chk_busy(1'b1, "busy_start");
    for (int i = 1; i < 16; i++) begin
      v = v_idle();
      if (i == 2) v = mk(1'b0, 1'b1, 1'b1, 5'd2, 16'h1234, 2'b11, 1'b1, 5'd2, 1'b0, 16'h0);
      if (i == 5) v = mk(1'b1, 1'b1, 1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd9, 1'b0, 16'h0);
      apply(v, "sweep");
      chk_busy(1'b1, "busy_sweep");
    end
    apply(v_idle(), "sweep_end");
    chk_busy(1'b0, "busy_done");
    for (int k = 0; k < 16; k++) apply(v_rd(5'(k), 16'h0000), "post_clear");
    apply(v_idle(), "drain");
    apply(v_idle(), "drain");

    // Reset in the middle of a sweep. Chip_Select is low to show it does not
    // gate the clear.
    for (int k = 0; k < 16; k++) apply(v_wr(5'(k), 16'hFFFF, 2'b11), "refill_ff");
    apply(mk(1'b1, 1'b0, 1'b0, 5'd0, 16'h0, 2'b00, 1'b0, 5'd0, 1'b0, 16'h0), "clr2_start");
    chk_busy(1'b1, "busy_clr2");
    for (int i = 0; i < 4; i++) begin
      apply(v_idle(), "clr2_sweep");
      chk_busy(1'b1, "busy_clr2_sweep");
    end
    Rst_n = 1'b0;
    sb.delete();
    last_data = 16'h0;
    apply(v_idle(), "rst_mid");
    chk_busy(1'b0, "busy_after_rst");
    Rst_n = 1'b1;
    for (int k = 0; k < 4; k++)  apply(v_rd(5'(k), 16'h0000), "rst_cleared");
    for (int k = 8; k < 16; k++) apply(v_rd(5'(k), 16'hFFFF), "rst_kept");
    apply(v_idle(), "drain");
    apply(v_idle(), "drain");
    apply(v_idle(), "drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
